// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: single-cycle 32x32 multiply, mthi/mtlo moves, and an optional
// 32-cycle radix-2 restoring divider compiled in only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        lo_wen,
  input  logic        hi_wen,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef MUL_DIV_UNIT_DIV_EN
    , S_DIV = 2'd2
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                sgn_q, sgn_d;
  logic                can_req, any_op;
  logic [2*DATA_W-1:0] a_ext, b_ext, prod;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic [DATA_W-1:0]   quo_q, quo_d, rem_q, rem_d, quo_nx, rem_nx;
  logic [5:0]          cnt_q, cnt_d;
  logic                negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic [DATA_W:0]     shifted;
  logic                ge;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? (~x + 32'd1) : x;
  endfunction

  // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign ge      = (shifted >= {1'b0, b_q});
  assign rem_nx  = ge ? (shifted[DATA_W-1:0] - b_q) : shifted[DATA_W-1:0];
  assign quo_nx  = {quo_q[DATA_W-2:0], ge};
`endif

  assign busy    = (state_q != S_IDLE);
  assign any_op  = is_div | is_divu | is_mult | is_multu;
  assign can_req = req_valid & ~busy & ~flush;

  // Operands widened to 64 bits so one unsigned multiply serves both signed and unsigned
  assign a_ext = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
  assign b_ext = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done    = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (can_req) begin
          if (is_div | is_divu) begin
`ifdef MUL_DIV_UNIT_DIV_EN
            a_d     = src_a;
            b_d     = mag(src_b, is_div);
            quo_d   = mag(src_a, is_div);
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = is_div & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            negr_d  = is_div & src_a[DATA_W-1];
            dz_d    = (src_b == '0);
            state_d = S_DIV;
`endif
          end else if (is_mult | is_multu) begin
            a_d     = src_a;
            b_d     = src_b;
            sgn_d   = is_mult;
            state_d = S_MUL;
          end else if (!any_op) begin
            if (lo_wen) lo_d = src_a;
            if (hi_wen) hi_d = src_a;
          end
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = prod;
          done         = 1'b1;
        end
      end
`ifdef MUL_DIV_UNIT_DIV_EN
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 6'd31) begin
          state_d = S_IDLE;
          done    = 1'b1;
          if (dz_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = negq_q ? (~quo_nx + 32'd1) : quo_nx;
            hi_d = negr_q ? (~rem_nx + 32'd1) : rem_nx;
          end
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + 6'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MUL_DIV_UNIT_DIV_EN
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit; divide tests adapt to whether MUL_DIV_UNIT_DIV_EN is defined.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_mult = 1'b0, is_multu = 1'b0, is_div = 1'b0, is_divu = 1'b0;
  logic        lo_wen = 1'b0, hi_wen = 1'b0;
  logic [31:0] src_a = 32'd0, src_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;
  bit          pend = 1'b0;

`ifdef MUL_DIV_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mul_div_unit dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid),
    .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
    .lo_wen(lo_wen), .hi_wen(hi_wen), .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: op 0=div, 1=divu, 2=mult, 3=multu; returns {hi, lo}
  function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      0: if (b == 32'd0) return {a, 32'hFFFFFFFF};
         else return {32'(sa % sb), 32'(sa / sb)};
      1: if (b == 32'd0) return {a, 32'hFFFFFFFF};
         else return {32'(ua % ub), 32'(ua / ub)};
      2: return 64'(sa * sb);
      default: return 64'(ua * ub);
    endcase
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: on each done, the following cycle must show the scoreboard's {hi,lo}
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      if (sb_q.size() > 0) chk("wb_hilo", {hi, lo}, sb_q.pop_front());
    end
    if (resetn && done) begin
      if (sb_q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
      else pend = 1'b1;
    end
  end

  task automatic clear_req();
    req_valid = 1'b0;
    is_div = 1'b0; is_divu = 1'b0; is_mult = 1'b0; is_multu = 1'b0;
    hi_wen = 1'b0; lo_wen = 1'b0;
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input bit extra, input bit with_mv);
    int n, dn, exp_n;
    bit acc;
    logic [63:0] e;
    acc   = DIV_EN || (op >= 2);
    exp_n = acc ? ((op >= 2) ? 1 : 32) : 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    is_div   = (op == 0);
    is_divu  = (op == 1) || (extra && op < 1);
    is_mult  = (op == 2) || (extra && op < 2);
    is_multu = (op == 3) || (extra && op < 3);
    hi_wen = with_mv; lo_wen = with_mv;
    src_a = a; src_b = b;
    if (acc) begin
      e = model(op, a, b);
      sb_q.push_back(e);
      hi_m = e[63:32];
      lo_m = e[31:0];
    end
    @(posedge clk); #1;
    clear_req();
    n = 0; dn = -1;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (done) dn = n;
    end
    chk("busy_len", 64'(n), 64'(exp_n));
    if (acc) chk("done_last_busy", 64'(dn), 64'(n));
    chk("hilo_after_op", {hi, lo}, {hi_m, lo_m});
  endtask

  task automatic do_move(input bit wh, input bit wl, input logic [31:0] v, input bit fl);
    @(posedge clk); #1;
    req_valid = 1'b1; hi_wen = wh; lo_wen = wl; src_a = v; flush = fl;
    if (!fl) begin
      if (wh) hi_m = v;
      if (wl) lo_m = v;
    end
    @(posedge clk); #1;
    clear_req();
    flush = 1'b0;
    @(negedge clk);
    chk("move_hilo", {hi, lo}, {hi_m, lo_m});
  endtask

  initial begin
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_op(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2, 32'hFFFFFFFD, 32'h00000005, 1'b0, 1'b0);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(3, 32'd7, 32'd9, 1'b0, 1'b1);
    chk("op_beats_move", {hi, lo}, 64'd63);

    run_op(0, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
    if (DIV_EN) chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    else        chk("div_dropped", {hi, lo}, 64'd63);
    run_op(1, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op(0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    if (DIV_EN) chk("div_ovf", {hi, lo}, 64'h00000000_80000000);

    // Requests that must be dropped
    @(posedge clk); #1;
    is_multu = 1'b1; src_a = 32'd5; src_b = 32'd5;
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("no_valid_drop", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; is_mult = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    clear_req(); flush = 1'b0;
    @(negedge clk);
    chk("flush_req_drop", 64'(busy), 64'd0);
    do_move(1'b1, 1'b0, 32'hDEAD0000, 1'b1);

    // Flush in the mult writeback cycle
    do_move(1'b1, 1'b0, 32'h1111, 1'b0);
    do_move(1'b0, 1'b1, 32'h2222, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; is_mult = 1'b1; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1;
    clear_req(); flush = 1'b1;
    @(negedge clk);
    chk("mul_flush_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("mul_flush_busy", 64'(busy), 64'd0);
    chk("mul_flush_hilo", {hi, lo}, 64'h00001111_00002222);

    // Flush divu in its 10th busy cycle
    @(posedge clk); #1;
    req_valid = 1'b1; is_divu = 1'b1; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk); #1;
    clear_req();
    repeat (9) @(posedge clk);
    #1;
    chk("div10_busy", 64'(busy), 64'(DIV_EN));
    flush = 1'b1;
    @(negedge clk);
    chk("div_flush_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("div_flush_busy", 64'(busy), 64'd0);
    chk("div_flush_hilo", {hi, lo}, 64'h00001111_00002222);

    // mthi while busy is ignored; reissued when idle it lands
    @(posedge clk); #1;
    req_valid = 1'b1; is_multu = 1'b1; src_a = 32'd3; src_b = 32'd4;
    sb_q.push_back(64'd12);
    hi_m = 32'd0; lo_m = 32'd12;
    @(posedge clk); #1;
    clear_req();
    req_valid = 1'b1; hi_wen = 1'b1; src_a = 32'h1234;
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("mthi_busy_ignored", {hi, lo}, 64'd12);
    do_move(1'b1, 1'b0, 32'h1234, 1'b0);
    chk("mthi_idle", 64'(hi), 64'h1234);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
      else
        run_op(int'($urandom_range(0, 3)), rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset pulse during a divide
    do_move(1'b1, 1'b1, 32'hABCD, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; is_divu = 1'b1; src_a = 32'd50; src_b = 32'd3;
    @(posedge clk); #1;
    clear_req();
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    sb_q.delete();
    hi_m = 32'd0; lo_m = 32'd0;
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op(2, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    chk("post_rst_mult", {hi, lo}, 64'h40000000_00000000);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port req_valid, input, 1, decode-stage instruction valid; qualifies all request inputs.
REQ-004 The block SHALL have ports is_mult, is_multu, is_div and is_divu, input, 1 each, operation select from the decoder.
REQ-005 The block SHALL have ports lo_wen and hi_wen, input, 1 each, mtlo/mthi write strobes.
REQ-006 The block SHALL have ports src_a and src_b, input, 32 each, rs_data and rt_data operands (dividend/divisor, multiplicand/multiplier).
REQ-007 The block SHALL have port flush, input, 1, exception/eret cancel of in-flight work.
REQ-008 The block SHALL have port busy, output, 1, unit occupied; the pipeline stalls mfhi/mflo/mthi/mtlo/mul/div while high.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse in the cycle HI/LO take a mul/div result.
REQ-010 The block SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.

Function
REQ-011 States SHALL be IDLE, MUL and DIV; busy SHALL be 1 exactly in MUL and DIV.
REQ-012 A request SHALL be accepted in cycle T iff req_valid=1, busy=0, flush=0 and one op flag is set; requests failing any condition SHALL be dropped without side effect.
REQ-013 Multiple op flags SHALL resolve by priority div > divu > mult > multu.
REQ-014 Accepting mult/multu SHALL register the operands, then enter MUL at T+1; the 64-bit product {hi,lo} SHALL be written at the end of T+1, with done=1 in T+1 and IDLE in T+2.
REQ-015 mult SHALL treat operands as two's complement and multu as unsigned; the full 64-bit product SHALL be kept.
REQ-016 Accepting div/divu SHALL enter DIV at T+1 with a 6-bit iteration counter; 32 radix-2 restoring iterations SHALL run in T+1..T+32 on operand magnitudes.
REQ-017 In the last iteration cycle (T+32), lo SHALL take the quotient and hi the remainder, with done=1 and IDLE in T+33.
REQ-018 For div, the quotient SHALL be negated iff the operand signs differ, and the remainder SHALL take the sign of src_a.
REQ-019 For divide by zero (div or divu), lo SHALL be 0xFFFFFFFF and hi SHALL be src_a unchanged, with the full 32-cycle latency.
REQ-020 For div 0x80000000/0xFFFFFFFF, lo SHALL be 0x80000000 and hi SHALL be 0.
REQ-021 lo_wen/hi_wen SHALL write src_a into lo/hi at the end of cycle T when req_valid=1, busy=0 and flush=0; otherwise they SHALL be ignored.
REQ-022 An op flag and lo_wen/hi_wen in the same cycle SHALL let the op win, dropping the move.
REQ-023 flush=1 in MUL or DIV SHALL abort the operation, give IDLE, busy=0 and done=0 next cycle, and leave hi/lo unchanged.
REQ-024 flush=1 in the writeback cycle SHALL suppress the writeback and the done pulse.
REQ-025 hi/lo SHALL change only via REQ-014, REQ-017 or REQ-021.

Reset
REQ-026 resetn=0 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0 and clear the counter and operand registers, including mid-operation.
REQ-027 The first request SHALL be accepted no earlier than the first rising clk edge after resetn rises.

Configuration
REQ-028 With macro MUL_DIV_UNIT_DIV_EN defined, div/divu SHALL behave per REQ-016..REQ-020.
REQ-029 Without MUL_DIV_UNIT_DIV_EN, div/divu SHALL be dropped (busy stays 0, hi/lo unchanged, no done), the DIV state and divider datapath SHALL be absent, and multiply/move behaviour SHALL be identical.

Verification
REQ-030 multu 0xFFFFFFFF*0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 visible at T+2; busy high one cycle; done in T+1.
REQ-031 mult 0xFFFFFFFD*0x00000005: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 div 0xFFFFFFF9/0x00000002: lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+33; busy high exactly 32 cycles.
REQ-033 divu 100/0: lo=0xFFFFFFFF, hi=100; div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-034 Load hi=0x1111/lo=0x2222 via mthi/mtlo; start divu; flush in the 10th busy cycle: busy=0 next cycle, no done, hi=0x1111, lo=0x2222.
REQ-035 mthi 0x1234 issued while busy: ignored; reissued after busy falls: hi=0x1234 next cycle; resetn pulse mid-DIV: all outputs 0 immediately.
